// File: rtl/hawk_axird_master.sv
// hawk_axird_master: single-beat AXI4 read master with a credit-reserved, in-order response FIFO.
// Optional sticky RRESP error flag is built when HAWK_AXIRD_RRESP_CHECK_EN is defined.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 1
`endif
`ifndef HACD_AXI4_BURST_SIZE
`define HACD_AXI4_BURST_SIZE 3'd3
`endif
`ifndef HACD_AXI4_BURST_TYPE
`define HACD_AXI4_BURST_TYPE 2'b01
`endif
`ifndef HACD_AXI_MASTER_FIFO_DEPTH
`define HACD_AXI_MASTER_FIFO_DEPTH 8
`endif

module hawk_axird_master #(
  parameter int         DATA_WIDTH      = `HACD_AXI4_DATA_WIDTH,
  parameter int         ADDR_WIDTH      = `HACD_AXI4_ADDR_WIDTH,
  parameter int         ID_WIDTH        = `HACD_AXI4_ID_WIDTH,
  parameter int         USER_WIDTH      = `HACD_AXI4_USER_WIDTH,
  parameter logic [2:0] BURST_SIZE      = `HACD_AXI4_BURST_SIZE,
  parameter logic [1:0] BURST_TYPE      = `HACD_AXI4_BURST_TYPE,
  parameter int         FIFO_DEPTH      = `HACD_AXI_MASTER_FIFO_DEPTH,
  parameter int         MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rdfifo_empty,
  output logic                  rd_err,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic [USER_WIDTH-1:0] m_axi_aruser,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic [USER_WIDTH-1:0] m_axi_ruser,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic {IDLE, ISSUE} ar_state_t;

  ar_state_t             state_q, state_d;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [OW-1:0]         outstanding_q;
  logic [CW-1:0]         occupancy_q;
  logic [PW:0]           wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         out_q;
  logic                  out_valid_q;
  logic [31:0]           credit_sum;
  logic                  credit_ok, ar_accept, push, pop, load_out, fifo_full, fifo_empty;
  logic                  unused_ok;

  assign unused_ok = ^{m_axi_rid, m_axi_rlast, m_axi_ruser};

  assign m_axi_arid     = '0;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = '0;
  assign m_axi_arsize   = BURST_SIZE;
  assign m_axi_arburst  = BURST_TYPE;
  assign m_axi_arprot   = 3'b010;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = '0;
  assign m_axi_arqos    = '0;
  assign m_axi_arregion = '0;
  assign m_axi_aruser   = '0;

  // FIFO space is reserved when the client request is accepted, not when the AR issues
  assign credit_sum = 32'(outstanding_q) + 32'(occupancy_q);
  assign credit_ok  = (credit_sum < 32'(FIFO_DEPTH)) && (outstanding_q < OW'(MAX_OUTSTANDING));

  always_comb begin
    state_d       = state_q;
    s_axi_arready = run_q && (state_q == IDLE) && credit_ok;
    m_axi_arvalid = (state_q == ISSUE);
    ar_accept     = s_axi_arvalid && s_axi_arready;
    unique case (state_q)
      IDLE:    if (ar_accept) state_d = ISSUE;
      ISSUE:   if (m_axi_arready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      araddr_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (ar_accept) araddr_q <= s_axi_araddr;
    end
  end

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign m_axi_rready = !fifo_full;
  // A beat arriving with nothing outstanding is a protocol error and is discarded
  assign push         = m_axi_rvalid && m_axi_rready && (outstanding_q != '0);
  assign pop          = out_valid_q && s_axi_rready;
  assign load_out     = !fifo_empty && (!out_valid_q || s_axi_rready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      occupancy_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_q         <= '0;
    end else begin
      unique case ({ar_accept, push})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      unique case ({push, pop})
        2'b10:   occupancy_q <= occupancy_q + CW'(1);
        2'b01:   occupancy_q <= occupancy_q - CW'(1);
        default: occupancy_q <= occupancy_q;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (load_out) begin
        rd_ptr_q    <= rd_ptr_q + (PW+1)'(1);
        out_q       <= mem_q[rd_ptr_q[PW-1:0]];
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {m_axi_rresp, m_axi_rdata};
  end

  assign s_axi_rvalid = out_valid_q;
  assign s_axi_rdata  = out_q[DATA_WIDTH-1:0];
  assign s_axi_rresp  = out_q[EW-1 -: 2];
  assign rdfifo_empty = (occupancy_q == '0);

`ifdef HAWK_AXIRD_RRESP_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                           rd_err <= 1'b0;
    else if (pop && s_axi_rresp != 2'b00) rd_err <= 1'b1;
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_axird_master.sv
// Directed bench for hawk_axird_master: instance 0 is FIFO_DEPTH=16/MAX_OUTSTANDING=16,
// instance 1 is FIFO_DEPTH=4/MAX_OUTSTANDING=2 for the credit and outstanding limits.
module tb_hawk_axird_master;

`ifdef HAWK_AXIRD_RRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        empty [2], rd_err [2];
  logic [31:0] s_araddr [2];
  logic        s_arvalid [2], s_arready [2];
  logic [31:0] s_rdata [2];
  logic [1:0]  s_rresp [2];
  logic        s_rvalid [2], s_rready [2];
  logic [3:0]  m_arid [2];
  logic [31:0] m_araddr [2];
  logic [7:0]  m_arlen [2];
  logic [2:0]  m_arsize [2], m_arprot [2];
  logic [1:0]  m_arburst [2];
  logic        m_arlock [2], m_aruser [2];
  logic [3:0]  m_arcache [2], m_arqos [2], m_arregion [2];
  logic        m_arvalid [2], m_arready [2];
  logic [31:0] m_rdata [2];
  logic [1:0]  m_rresp [2];
  logic        m_rvalid [2], m_rready [2];

  int n_cmp = 0;
  int n_bad = 0;

  hawk_axird_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(1),
    .BURST_SIZE(3'd2), .BURST_TYPE(2'b01), .FIFO_DEPTH(16), .MAX_OUTSTANDING(16)
  ) u_big (
    .clk(clk), .rst_n(rst_n), .rdfifo_empty(empty[0]), .rd_err(rd_err[0]),
    .s_axi_araddr(s_araddr[0]), .s_axi_arvalid(s_arvalid[0]), .s_axi_arready(s_arready[0]),
    .s_axi_rdata(s_rdata[0]), .s_axi_rresp(s_rresp[0]), .s_axi_rvalid(s_rvalid[0]), .s_axi_rready(s_rready[0]),
    .m_axi_arid(m_arid[0]), .m_axi_araddr(m_araddr[0]), .m_axi_arlen(m_arlen[0]), .m_axi_arsize(m_arsize[0]),
    .m_axi_arburst(m_arburst[0]), .m_axi_arprot(m_arprot[0]), .m_axi_arlock(m_arlock[0]),
    .m_axi_arcache(m_arcache[0]), .m_axi_arqos(m_arqos[0]), .m_axi_arregion(m_arregion[0]),
    .m_axi_aruser(m_aruser[0]), .m_axi_arvalid(m_arvalid[0]), .m_axi_arready(m_arready[0]),
    .m_axi_rid(4'd0), .m_axi_rdata(m_rdata[0]), .m_axi_rresp(m_rresp[0]), .m_axi_rlast(1'b1),
    .m_axi_ruser(1'b0), .m_axi_rvalid(m_rvalid[0]), .m_axi_rready(m_rready[0])
  );

  hawk_axird_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(1),
    .BURST_SIZE(3'd2), .BURST_TYPE(2'b01), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .rdfifo_empty(empty[1]), .rd_err(rd_err[1]),
    .s_axi_araddr(s_araddr[1]), .s_axi_arvalid(s_arvalid[1]), .s_axi_arready(s_arready[1]),
    .s_axi_rdata(s_rdata[1]), .s_axi_rresp(s_rresp[1]), .s_axi_rvalid(s_rvalid[1]), .s_axi_rready(s_rready[1]),
    .m_axi_arid(m_arid[1]), .m_axi_araddr(m_araddr[1]), .m_axi_arlen(m_arlen[1]), .m_axi_arsize(m_arsize[1]),
    .m_axi_arburst(m_arburst[1]), .m_axi_arprot(m_arprot[1]), .m_axi_arlock(m_arlock[1]),
    .m_axi_arcache(m_arcache[1]), .m_axi_arqos(m_arqos[1]), .m_axi_arregion(m_arregion[1]),
    .m_axi_aruser(m_aruser[1]), .m_axi_arvalid(m_arvalid[1]), .m_axi_arready(m_arready[1]),
    .m_axi_rid(4'd0), .m_axi_rdata(m_rdata[1]), .m_axi_rresp(m_rresp[1]), .m_axi_rlast(1'b1),
    .m_axi_ruser(1'b0), .m_axi_rvalid(m_rvalid[1]), .m_axi_rready(m_rready[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int d, input logic [31:0] addr, output bit ok);
    int n = 0;
    s_araddr[d]  = addr;
    s_arvalid[d] = 1'b1;
    while (s_arready[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    ok = (s_arready[d] === 1'b1);
    step();
    s_arvalid[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      s_araddr[d] = '0; s_arvalid[d] = 1'b0; s_rready[d] = 1'b0; m_arready[d] = 1'b0;
      m_rdata[d] = '0; m_rresp[d] = '0; m_rvalid[d] = 1'b0;
    end
    rst_n = 1'b0;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (m_arvalid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid[%0d]: got %b want 0", d, m_arvalid[d]); end
      n_cmp++; if (s_arready[d] !== 1'b0) begin n_bad++; $display("FAIL reset_arready[%0d]: got %b want 0", d, s_arready[d]); end
      n_cmp++; if (s_rvalid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid[%0d]: got %b want 0", d, s_rvalid[d]); end
      n_cmp++; if (empty[d] !== 1'b1) begin n_bad++; $display("FAIL reset_empty[%0d]: got %b want 1", d, empty[d]); end
      n_cmp++; if (rd_err[d] !== 1'b0) begin n_bad++; $display("FAIL reset_rd_err[%0d]: got %b want 0", d, rd_err[d]); end
    end
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_single_read();
    bit ok;
    accept(0, 32'h1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_accept: arready never seen, got %b want 1", ok); end
    n_cmp++; if (m_arvalid[0] !== 1'b1) begin n_bad++; $display("FAIL single_arvalid: got %b want 1", m_arvalid[0]); end
    n_cmp++; if (m_araddr[0] !== 32'h1000) begin n_bad++; $display("FAIL single_araddr: got %h want 00001000", m_araddr[0]); end
    n_cmp++; if (m_arlen[0] !== 8'd0) begin n_bad++; $display("FAIL single_arlen: got %h want 00", m_arlen[0]); end
    n_cmp++; if ({m_arsize[0], m_arburst[0], m_arprot[0]} !== {3'd2, 2'b01, 3'b010}) begin n_bad++; $display("FAIL single_ar_fields: got size %h burst %h prot %h want 2 1 2", m_arsize[0], m_arburst[0], m_arprot[0]); end
    n_cmp++; if ({m_arid[0], m_arlock[0], m_arcache[0], m_arqos[0], m_arregion[0], m_aruser[0]} !== 18'd0) begin n_bad++; $display("FAIL single_ar_zero_fields: got nonzero want 0"); end
    m_arready[0] = 1'b1;
    step();
    m_arready[0] = 1'b0;
    n_cmp++; if (m_arvalid[0] !== 1'b0) begin n_bad++; $display("FAIL single_arvalid_drop: got %b want 0", m_arvalid[0]); end
    m_rvalid[0] = 1'b1; m_rdata[0] = 32'hA5; m_rresp[0] = 2'b00;
    n_cmp++; if (m_rready[0] !== 1'b1) begin n_bad++; $display("FAIL single_rready: got %b want 1", m_rready[0]); end
    step();
    m_rvalid[0] = 1'b0;
    n_cmp++; if (s_rvalid[0] !== 1'b0) begin n_bad++; $display("FAIL single_latency_n1: got %b want 0", s_rvalid[0]); end
    step();
    n_cmp++; if (s_rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL single_latency_n2: got %b want 1", s_rvalid[0]); end
    n_cmp++; if (s_rdata[0] !== 32'hA5) begin n_bad++; $display("FAIL single_rdata: got %h want 000000a5", s_rdata[0]); end
    n_cmp++; if (empty[0] !== 1'b0) begin n_bad++; $display("FAIL single_not_empty: got %b want 0", empty[0]); end
    s_rready[0] = 1'b1;
    step();
    s_rready[0] = 1'b0;
    n_cmp++; if (s_rvalid[0] !== 1'b0) begin n_bad++; $display("FAIL single_pop_rvalid: got %b want 0", s_rvalid[0]); end
    n_cmp++; if (empty[0] !== 1'b1) begin n_bad++; $display("FAIL single_pop_empty: got %b want 1", empty[0]); end
  endtask

  task automatic test_ar_stall();
    bit ok;
    accept(0, 32'h2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_accept: got %b want 1", ok); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (m_arvalid[0] !== 1'b1) begin n_bad++; $display("FAIL stall_arvalid c%0d: got %b want 1", i, m_arvalid[0]); end
      n_cmp++; if (m_araddr[0] !== 32'h2000) begin n_bad++; $display("FAIL stall_araddr c%0d: got %h want 00002000", i, m_araddr[0]); end
      n_cmp++; if (s_arready[0] !== 1'b0) begin n_bad++; $display("FAIL stall_s_arready c%0d: got %b want 0", i, s_arready[0]); end
      step();
    end
    m_arready[0] = 1'b1;
    step();
    m_arready[0] = 1'b0;
    m_rvalid[0] = 1'b1; m_rdata[0] = 32'h5A5A; m_rresp[0] = 2'b00;
    step();
    m_rvalid[0] = 1'b0;
    step();
    n_cmp++; if ({s_rvalid[0], s_rdata[0]} !== {1'b1, 32'h5A5A}) begin n_bad++; $display("FAIL stall_rdata: got v%b %h want v1 00005a5a", s_rvalid[0], s_rdata[0]); end
    s_rready[0] = 1'b1;
    step();
    s_rready[0] = 1'b0;
  endtask

  task automatic test_credit_limit();
    int acc = 0, iss = 0, pend = 0, rcnt = 0, got = 0;
    bit add;
    s_rready[1] = 1'b0; m_arready[1] = 1'b1; m_rresp[1] = 2'b00;
    s_araddr[1] = 32'h3000; s_arvalid[1] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      m_rvalid[1] = (pend > 0);
      m_rdata[1]  = 32'h300 + 32'(rcnt);
      if (s_arvalid[1] && s_arready[1]) acc++;
      add = m_arvalid[1] && m_arready[1];
      if (m_rvalid[1] && m_rready[1]) begin pend--; rcnt++; end
      step();
      if (add) begin iss++; pend++; end
      s_araddr[1] = 32'h3000 + 32'(acc * 4);
    end
    m_rvalid[1] = 1'b0;
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL credit_accepts: got %0d want 4", acc); end
    n_cmp++; if (iss !== 4) begin n_bad++; $display("FAIL credit_issued: got %0d want 4", iss); end
    n_cmp++; if (rcnt !== 4) begin n_bad++; $display("FAIL credit_r_beats: got %0d want 4", rcnt); end
    n_cmp++; if (s_arready[1] !== 1'b0) begin n_bad++; $display("FAIL credit_blocked: got %b want 0", s_arready[1]); end
    n_cmp++; if (s_rdata[1] !== 32'h300) begin n_bad++; $display("FAIL credit_head: got %h want 00000300", s_rdata[1]); end
    s_rready[1] = 1'b1;
    step();
    s_rready[1] = 1'b0;
    n_cmp++; if (s_arready[1] !== 1'b1) begin n_bad++; $display("FAIL credit_freed: got %b want 1", s_arready[1]); end
    step();
    s_arvalid[1] = 1'b0;
    n_cmp++; if (m_arvalid[1] !== 1'b1) begin n_bad++; $display("FAIL credit_fifth_ar: got %b want 1", m_arvalid[1]); end
    step();
    m_arready[1] = 1'b0;
    m_rvalid[1] = 1'b1; m_rdata[1] = 32'h304;
    step();
    m_rvalid[1] = 1'b0;
    s_rready[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (s_rvalid[1] === 1'b1) begin
        n_cmp++; if (s_rdata[1] !== 32'h301 + 32'(got)) begin n_bad++; $display("FAIL credit_order beat%0d: got %h want %h", got, s_rdata[1], 32'h301 + 32'(got)); end
        got++;
      end
      step();
    end
    s_rready[1] = 1'b0;
    n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL credit_drain_count: got %0d want 4", got); end
    n_cmp++; if (empty[1] !== 1'b1) begin n_bad++; $display("FAIL credit_drain_empty: got %b want 1", empty[1]); end
  endtask

  task automatic test_outstanding_limit();
    int iss = 0;
    s_rready[1] = 1'b1; m_arready[1] = 1'b1; m_rresp[1] = 2'b00;
    s_araddr[1] = 32'h5000; s_arvalid[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (m_arvalid[1] && m_arready[1]) iss++;
      step();
    end
    n_cmp++; if (iss !== 2) begin n_bad++; $display("FAIL outst_issued: got %0d want 2", iss); end
    n_cmp++; if (s_arready[1] !== 1'b0) begin n_bad++; $display("FAIL outst_blocked: got %b want 0", s_arready[1]); end
    m_rvalid[1] = 1'b1; m_rdata[1] = 32'h400;
    step();
    m_rvalid[1] = 1'b0;
    iss = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_arvalid[1] && m_arready[1]) iss++;
      step();
    end
    s_arvalid[1] = 1'b0;
    n_cmp++; if (iss !== 1) begin n_bad++; $display("FAIL outst_third: got %0d want 1", iss); end
    m_rvalid[1] = 1'b1;
    step();
    step();
    m_rvalid[1] = 1'b0;
    m_arready[1] = 1'b0;
    for (int c = 0; c < 4; c++) step();
    n_cmp++; if (empty[1] !== 1'b1) begin n_bad++; $display("FAIL outst_drained: got %b want 1", empty[1]); end
    // stray beat with nothing outstanding: accepted and discarded
    m_rvalid[1] = 1'b1; m_rdata[1] = 32'hBAD;
    n_cmp++; if (m_rready[1] !== 1'b1) begin n_bad++; $display("FAIL stray_rready: got %b want 1", m_rready[1]); end
    step();
    m_rvalid[1] = 1'b0;
    step();
    step();
    n_cmp++; if (s_rvalid[1] !== 1'b0) begin n_bad++; $display("FAIL stray_rvalid: got %b want 0", s_rvalid[1]); end
    n_cmp++; if (empty[1] !== 1'b1) begin n_bad++; $display("FAIL stray_empty: got %b want 1", empty[1]); end
    n_cmp++; if (s_arready[1] !== 1'b1) begin n_bad++; $display("FAIL stray_arready: got %b want 1", s_arready[1]); end
    s_rready[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic exp_v;
    m_arready[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      accept(0, 32'h4000 + 32'(i * 64), ok);
      n_cmp++; if ({ok, m_araddr[0]} !== {1'b1, 32'h4000 + 32'(i * 64)}) begin n_bad++; $display("FAIL b2b_ar%0d: got ok%b %h want ok1 %h", i, ok, m_araddr[0], 32'h4000 + 32'(i * 64)); end
      step();
    end
    m_arready[0] = 1'b0;
    s_rready[0] = 1'b1; m_rresp[0] = 2'b00;
    for (int k = 0; k < 19; k++) begin
      m_rvalid[0] = (k < 16);
      m_rdata[0]  = 32'h100 + 32'(k);
      step();
      exp_v = (k >= 1 && k <= 16);
      n_cmp++; if (s_rvalid[0] !== exp_v || (exp_v && s_rdata[0] !== 32'h100 + 32'(k - 1))) begin n_bad++; $display("FAIL b2b_beat c%0d: got v%b %h want v%b %h", k, s_rvalid[0], s_rdata[0], exp_v, 32'h100 + 32'(k - 1)); end
    end
    s_rready[0] = 1'b0;
    n_cmp++; if (empty[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: got %b want 1", empty[0]); end
  endtask

  task automatic test_error();
    bit ok;
    accept(0, 32'h6000, ok);
    m_arready[0] = 1'b1;
    step();
    m_arready[0] = 1'b0;
    m_rvalid[0] = 1'b1; m_rdata[0] = 32'hDEAD; m_rresp[0] = 2'b10;
    step();
    m_rvalid[0] = 1'b0; m_rresp[0] = 2'b00;
    step();
    n_cmp++; if ({ok, s_rvalid[0], s_rresp[0], s_rdata[0]} !== {1'b1, 1'b1, 2'b10, 32'hDEAD}) begin n_bad++; $display("FAIL err_beat: got ok%b v%b resp %b %h want ok1 v1 10 0000dead", ok, s_rvalid[0], s_rresp[0], s_rdata[0]); end
    n_cmp++; if (rd_err[0] !== 1'b0) begin n_bad++; $display("FAIL err_before_pop: got %b want 0", rd_err[0]); end
    s_rready[0] = 1'b1;
    step();
    s_rready[0] = 1'b0;
    n_cmp++; if (rd_err[0] !== EXP_ERR) begin n_bad++; $display("FAIL err_set: got %b want %b", rd_err[0], EXP_ERR); end
    for (int c = 0; c < 3; c++) step();
    n_cmp++; if (rd_err[0] !== EXP_ERR) begin n_bad++; $display("FAIL err_sticky: got %b want %b", rd_err[0], EXP_ERR); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (rd_err[0] !== 1'b0) begin n_bad++; $display("FAIL err_reset_clear: got %b want 0", rd_err[0]); end
    n_cmp++; if (empty[0] !== 1'b1) begin n_bad++; $display("FAIL err_reset_empty: got %b want 1", empty[0]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_ar_stall();
    test_back_to_back();
    test_credit_limit();
    test_outstanding_limit();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
